// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
// The environment uses frame_len() to size its timeouts.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TXS_IDLE   = 3'd0,
        TXS_START  = 3'd1,
        TXS_DATA   = 3'd2,
        TXS_PARITY = 3'd3,
        TXS_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RXS_IDLE      = 3'd0,
        RXS_START     = 3'd1,
        RXS_DATA      = 3'd2,
        RXS_PARITY    = 3'd3,
        RXS_STOP      = 3'd4,
        RXS_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam logic [2:0] TX_IDLE      = TXS_IDLE;
    localparam logic [2:0] TX_START     = TXS_START;
    localparam logic [2:0] TX_DATA      = TXS_DATA;
    localparam logic [2:0] TX_PARITY    = TXS_PARITY;
    localparam logic [2:0] TX_STOP      = TXS_STOP;
    localparam logic [2:0] RX_IDLE      = RXS_IDLE;
    localparam logic [2:0] RX_START     = RXS_START;
    localparam logic [2:0] RX_DATA      = RXS_DATA;
    localparam logic [2:0] RX_PARITY    = RXS_PARITY;
    localparam logic [2:0] RX_STOP      = RXS_STOP;
    localparam logic [2:0] RX_WAIT_HIGH = RXS_WAIT_HIGH;

    function automatic int frame_len(input int data_bits, input int parity,
                                     input int stop_bits, input int clks);
        return (1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits) * clks;
    endfunction

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic par_bit(input logic [8:0] data, input parity_e mode);
        par_bit = (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a one-cycle tick every time it reaches zero;
// it reloads CLKS_PER_BIT-1 on its own, so a short first load sets the phase.
module uart_bit_timer #(
    parameter  int CLKS_PER_BIT = 434,
    localparam int W            = $clog2(CLKS_PER_BIT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: explicit load beats the free-running wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_d = W'(CLKS_PER_BIT - 1);
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART with parametrised word length, parity, stop bits and bit
// period. TX and RX share nothing but the clock and reset.
import uart_pkg::*;

module uart_core_param #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 txd,
    input  logic                 rxd,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int             TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam parity_e        PMODE     = parity_e'(PARITY);
    localparam logic           PAR_EN    = (PARITY != 0);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

    logic [2:0]           tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_load_s, tx_tick_s;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk        (clk),
        .reset      (reset),
        .en_i       (tx_busy_q),
        .load_i     (tx_load_s),
        .load_val_i (FULL_LOAD),
        .tick_o     (tx_tick_s)
    );

    // TX sequencing; txd is registered so it changes exactly on bit boundaries.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_ready_d = tx_ready_q;
        tx_busy_d  = tx_busy_q;
        tx_load_s  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_par_d   = par_bit(9'(tx_data), PMODE);
                    txd_d      = 1'b0;
                    tx_ready_d = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_load_s  = 1'b1;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_tick_s) begin
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_cnt_d   = 4'd0;
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_tick_s && (tx_cnt_q == LAST_DATA)) begin
                    tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
                    txd_d      = PAR_EN ? tx_par_q : 1'b1;
                    tx_cnt_d   = 4'd0;
                end else if (tx_tick_s) begin
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_cnt_d   = tx_cnt_q + 4'd1;
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_tick_s) begin
                    tx_state_d = TX_STOP;
                    txd_d      = 1'b1;
                    tx_cnt_d   = 4'd0;
                end else begin
                    tx_state_d = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (tx_tick_s && (tx_cnt_q == LAST_STOP)) begin
                    tx_state_d = TX_IDLE;
                    tx_ready_d = 1'b1;
                    tx_busy_d  = 1'b0;
                end else if (tx_tick_s) begin
                    tx_cnt_d   = tx_cnt_q + 4'd1;
                end else begin
                    tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
                tx_ready_d = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    // TX registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_cnt_q   <= 4'd0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_facc_q, rx_facc_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_en_s, rx_load_s, rx_tick_s;

    assign rx_en_s = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH);

    // The first load puts the tick at mid start bit; the wrap then keeps mid-bit.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk        (clk),
        .reset      (reset),
        .en_i       (rx_en_s),
        .load_i     (rx_load_s),
        .load_val_i (HALF_LOAD),
        .tick_o     (rx_tick_s)
    );

    // RX sequencing on the synchronised line.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        rx_par_d   = rx_par_q;
        rx_facc_d  = rx_facc_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_load_s  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_facc_d  = 1'b0;
                    rx_load_s  = 1'b1;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_tick_s) begin
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    rx_cnt_d   = 4'd0;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_tick_s) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_cnt_d   = (rx_cnt_q == LAST_DATA) ? 4'd0 : (rx_cnt_q + 4'd1);
                    rx_state_d = (rx_cnt_q != LAST_DATA) ? RX_DATA :
                                 (PAR_EN ? RX_PARITY : RX_STOP);
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (rx_tick_s) begin
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_state_d = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (rx_tick_s && (rx_cnt_q == LAST_STOP)) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_ferr_d  = rx_facc_q | ~rx_sync_q;
                    rx_perr_d  = PAR_EN && (rx_par_q != par_bit(9'(rx_shift_q), PMODE));
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end else if (rx_tick_s) begin
                    rx_facc_d  = rx_facc_q | ~rx_sync_q;
                    rx_cnt_d   = rx_cnt_q + 4'd1;
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_HIGH;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX registers, including the two-flop synchroniser idling high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_cnt_q   <= 4'd0;
            rx_par_q   <= 1'b0;
            rx_facc_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_par_q   <= rx_par_d;
            rx_facc_q  <= rx_facc_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign tx_ready      = tx_ready_q;
    assign tx_busy       = tx_busy_q;
    assign txd           = txd_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: unit A is 8E1, unit B is 7O2, both at 8 clocks per bit.
// Expected serial frames and received words come from a bit-list model of the frame.
module tb_uart_core_param;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, tx_valid_a, tx_ready_a, tx_busy_a, txd_a, rxd_a;
    logic       rx_valid_a, rx_perr_a, rx_ferr_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       reset_b, tx_valid_b, tx_ready_b, tx_busy_b, txd_b;
    logic       rx_valid_b, rx_perr_b, rx_ferr_b;
    logic [6:0] tx_data_b, rx_data_b;
    logic       loop_a, rxd_drv;

    assign rxd_a = loop_a ? txd_a : rxd_drv;

    uart_core_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(N)) u_a (
        .clk(clk), .reset(reset_a), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
        .tx_ready(tx_ready_a), .tx_busy(tx_busy_a), .txd(txd_a), .rxd(rxd_a),
        .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_parity_err(rx_perr_a),
        .rx_frame_err(rx_ferr_a));

    uart_core_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(N)) u_b (
        .clk(clk), .reset(reset_b), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
        .tx_ready(tx_ready_b), .tx_busy(tx_busy_b), .txd(txd_b), .rxd(txd_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_parity_err(rx_perr_b),
        .rx_frame_err(rx_ferr_b));

    typedef struct {
        int         u;
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } rec_t;

    rec_t recq[$];
    bit   frame_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Every received word from either unit, in arrival order.
    always @(negedge clk) begin
        if (rx_valid_a) recq.push_back('{0, {1'b0, rx_data_a}, rx_perr_a, rx_ferr_a});
        if (rx_valid_b) recq.push_back('{1, {2'b00, rx_data_b}, rx_perr_b, rx_ferr_b});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbits_of(input int u);  return (u == 0) ? 8 : 7; endfunction
    function automatic int pmode_of(input int u);  return (u == 0) ? 1 : 2; endfunction
    function automatic int nstop_of(input int u);  return (u == 0) ? 1 : 2; endfunction
    function automatic logic txd_of(input int u);   return (u == 0) ? txd_a : txd_b; endfunction
    function automatic logic ready_of(input int u); return (u == 0) ? tx_ready_a : tx_ready_b; endfunction
    function automatic logic busy_of(input int u);  return (u == 0) ? tx_busy_a : tx_busy_b; endfunction

    function automatic logic [8:0] mask_word(input logic [8:0] w, input int nbits);
        return w & 9'((1 << nbits) - 1);
    endfunction

    // Serial line contents of one frame, one entry per bit period.
    task automatic build_frame(input logic [8:0] w, input int nbits, input int pmode,
                               input int nstop, input bit flip_par, input bit stop_val);
        int ones;
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) frame_q.push_back(w[i]);
        ones = $countones(mask_word(w, nbits));
        if (pmode != 0) frame_q.push_back(((pmode == 2) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ flip_par);
        for (int s = 0; s < nstop; s++) frame_q.push_back(stop_val);
    endtask

    task automatic drive_tx(input int u, input logic v, input logic [8:0] w);
        if (u == 0) begin
            tx_valid_a = v;
            tx_data_a  = w[7:0];
        end else begin
            tx_valid_b = v;
            tx_data_b  = w[6:0];
        end
    endtask

    task automatic expect_rec(input string tag, input int u, input logic [8:0] d,
                              input logic pe, input logic fe);
        rec_t r;
        for (int k = 0; k < 40 && recq.size() == 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, "_count"}, recq.size(), 1);
        if (recq.size() > 0) r = recq.pop_front();
        else r = '{-1, 9'h1ff, 1'bx, 1'bx};
        check({tag, "_unit"}, r.u, u);
        check({tag, "_data"}, r.data, d);
        check({tag, "_perr"}, r.pe, pe);
        check({tag, "_ferr"}, r.fe, fe);
        recq.delete();
    endtask

    // Transmit one word in loopback and compare txd cycle by cycle with the model.
    task automatic send_word(input int u, input logic [8:0] w, input string tag);
        int bad = 0;
        int plen;
        build_frame(w, nbits_of(u), pmode_of(u), nstop_of(u), 1'b0, 1'b1);
        plen = frame_q.size() * N;
        check({tag, "_ready_before"}, ready_of(u), 1'b1);
        drive_tx(u, 1'b1, w);
        @(negedge clk);
        drive_tx(u, 1'b0, 9'h000);
        check({tag, "_accept"}, {ready_of(u), busy_of(u), txd_of(u)}, 3'b010);
        for (int j = 1; j <= plen; j++) begin
            if (j > 1) @(negedge clk);
            if (txd_of(u) !== frame_q[(j - 1) / N]) bad++;
            if (ready_of(u) !== 1'b0 || busy_of(u) !== 1'b1) bad++;
        end
        check({tag, "_wave_errs"}, bad, 0);
        @(negedge clk);
        check({tag, "_ready_after"}, {ready_of(u), busy_of(u), txd_of(u)}, 3'b101);
        expect_rec({tag, "_rx"}, u, mask_word(w, nbits_of(u)), 1'b0, 1'b0);
    endtask

    task automatic drive_frame_a(input logic [8:0] w, input bit flip_par, input bit stop_val);
        build_frame(w, 8, 1, 1, flip_par, stop_val);
        for (int i = 0; i < frame_q.size(); i++) begin
            rxd_drv = frame_q[i];
            repeat (N) @(negedge clk);
        end
    endtask

    initial begin
        logic [8:0] w;
        bit         flip;
        int         bad;

        reset_a = 1'b1; reset_b = 1'b1; loop_a = 1'b1; rxd_drv = 1'b1;
        drive_tx(0, 1'b1, 9'h0ff);
        drive_tx(1, 1'b1, 9'h000);

        // Reset state, with tx_valid held high throughout.
        repeat (5) @(negedge clk);
        check("rst_tx", {txd_a, tx_ready_a, tx_busy_a}, 3'b110);
        check("rst_rx", {rx_valid_a, rx_data_a, rx_perr_a, rx_ferr_a}, 11'd0);
        check("rst_b", {txd_b, tx_ready_b, tx_busy_b, rx_valid_b}, 4'b1100);
        reset_a = 1'b0; reset_b = 1'b0;
        drive_tx(0, 1'b0, 9'h000);
        drive_tx(1, 1'b0, 9'h000);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || tx_busy_a !== 1'b0) bad++;
        end
        check("rst_no_tx", bad, 0);
        check("rst_no_rx", recq.size(), 0);

        // Loopback: the directed word, then random words.
        send_word(0, 9'h0a5, "lb_a5");
        for (int i = 0; i < 4; i++) send_word(0, 9'($urandom_range(0, 255)), "lb_rand");

        // Wrong parity on a driven frame.
        loop_a = 1'b0;
        drive_frame_a(9'h03c, 1'b1, 1'b1);
        expect_rec("perr_3c", 0, 9'h03c, 1'b1, 1'b0);

        // Random driven frames with random parity corruption.
        for (int i = 0; i < 4; i++) begin
            w    = 9'($urandom_range(0, 255));
            flip = 1'($urandom_range(0, 1));
            drive_frame_a(w, flip, 1'b1);
            rxd_drv = 1'b1;
            expect_rec("rx_rand", 0, w, flip, 1'b0);
        end

        // Low stop bit followed by a held-low line.
        drive_frame_a(9'h055, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        expect_rec("ferr_55", 0, 9'h055, 1'b0, 1'b1);
        rxd_drv = 1'b1;
        repeat (16) @(negedge clk);
        check("ferr_no_second", recq.size(), 0);
        check("ferr_held", rx_ferr_a, 1'b1);
        w = 9'($urandom_range(0, 255));
        drive_frame_a(w, 1'b0, 1'b1);
        expect_rec("after_break", 0, w, 1'b0, 1'b0);

        // Three-cycle glitch must not start a frame.
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_rx", recq.size(), 0);
        drive_frame_a(9'h081, 1'b0, 1'b1);
        expect_rec("after_glitch", 0, 9'h081, 1'b0, 1'b0);
        loop_a = 1'b1;

        // 7O2 unit: 0x7F, then a reset in the middle of a second frame.
        send_word(1, 9'h07f, "b_7f");
        drive_tx(1, 1'b1, 9'($urandom_range(0, 127)));
        @(negedge clk);
        drive_tx(1, 1'b0, 9'h000);
        repeat (4 * N + 3) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        check("b_midreset", {txd_b, tx_ready_b, tx_busy_b}, 3'b110);
        repeat (30) @(negedge clk);
        check("b_midreset_no_rx", recq.size(), 0);
        send_word(1, 9'($urandom_range(0, 127)), "b_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
